// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared constants, state encoding and helpers for the Wishbone round-robin arbiter
package wb_arb_pkg;
  localparam int NM    = 4;
  localparam int PCIC  = 0;
  localparam int TURFC = 1;
  localparam int HKMC  = 2;
  localparam int WBVIO = 3;
  typedef enum logic [1:0] {IDLE, BUSY, TERR} state_t;
  function automatic logic [1:0] oh2idx(input logic [NM-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < NM; i++) if (oh[i]) oh2idx = 2'(i);
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker, searching last+1, last+2, ... mod 4
module rr_pick4
  import wb_arb_pkg::*;
(
  input  logic [NM-1:0] req,
  input  logic [1:0]    last,
  output logic [NM-1:0] gnt,
  output logic          valid
);
  logic [2:0]      sh;
  logic [NM-1:0]   rot;
  logic [NM-1:0]   low;
  logic [2*NM-1:0] back;
  // rotate so last+1 sits at bit 0, isolate the lowest request, rotate back
  assign sh    = {1'b0, last} + 3'd1;
  assign rot   = NM'({req, req} >> sh);
  assign low   = rot & (~rot + NM'(1));
  assign back  = {low, low} << sh;
  assign gnt   = back[2*NM-1:NM];
  assign valid = |req;
endmodule

// File: rtl/wbc_rr_arbiter.sv
// wbc_rr_arbiter: four-master round-robin Wishbone classic arbiter with a cycle-locked grant
// and a watchdog that turns a hung slave cycle into an err to the granted master.
module wbc_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 20,
  parameter int SW      = 4,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  input  logic [NM*SW-1:0] m_sel_i,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NM-1:0]    m_rty_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  output logic [SW-1:0]    s_sel_o,
  input  logic [DW-1:0]    s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  output logic [NM-1:0]    grant_o,
  output logic             timeout_o
);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t        state_q, state_d;
  logic [1:0]    last_q, last_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [NM-1:0] pick, gvec;
  logic          pick_v, busy, g_cyc, route, term, expire;
  rr_pick4 u_pick (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick),
    .valid(pick_v)
  );
  assign m_dat_o = s_dat_i;
  // last_q doubles as the index of the granted master once out of IDLE
  always_comb begin
    busy      = state_q == BUSY;
    gvec      = NM'(1) << last_q;
    g_cyc     = m_cyc_i[last_q];
    route     = busy & g_cyc;
    term      = s_ack_i | s_err_i | s_rty_i;
    s_cyc_o   = route;
    s_stb_o   = route & m_stb_i[last_q];
    s_we_o    = busy & m_we_i[last_q];
    s_adr_o   = busy ? m_adr_i[int'(last_q)*AW +: AW] : '0;
    s_dat_o   = busy ? m_dat_i[int'(last_q)*DW +: DW] : '0;
    s_sel_o   = busy ? m_sel_i[int'(last_q)*SW +: SW] : '0;
    m_ack_o   = (route & s_ack_i) ? gvec : '0;
    m_err_o   = (state_q == TERR || (route & s_err_i)) ? gvec : '0;
    m_rty_o   = (route & s_rty_i) ? gvec : '0;
    grant_o   = state_q == IDLE ? '0 : gvec;
    timeout_o = state_q == TERR;
    expire    = (TIMEOUT != 0) && s_stb_o && !term && cnt_q == TLAST;
    cnt_d     = (s_stb_o && !term && !expire) ? cnt_q + TW'(1) : '0;
    last_d    = (state_q == IDLE && pick_v) ? oh2idx(pick) : last_q;
    state_d   = state_q == IDLE ? (pick_v ? BUSY : IDLE) :
                state_q == TERR ? (g_cyc ? BUSY : IDLE) :
                !g_cyc ? IDLE : expire ? TERR : BUSY;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 2'(WBVIO);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_wbc_rr_arbiter.sv
// tb_wbc_rr_arbiter: directed scenarios plus randomized traffic checked against a transaction-level
// model that tracks owner, last winner and unanswered-strobe count.
module tb_wbc_rr_arbiter;
  import wb_arb_pkg::*;
  localparam int DW = 32, AW = 20, SW = 4, TO = 16, TW = 5;
  localparam int OW = 3 + AW + DW + SW + 16 + 1 + DW;
  logic clk_i, rst_n_i;
  logic [3:0] m_cyc_i, m_stb_i, m_we_i;
  logic [AW-1:0] adr[4];
  logic [DW-1:0] wdat[4];
  logic [SW-1:0] sel[4];
  logic [4*AW-1:0] m_adr_i;
  logic [4*DW-1:0] m_dat_i;
  logic [4*SW-1:0] m_sel_i;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic [3:0] m_ack_o, m_err_o, m_rty_o, grant_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i, timeout_o;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  int checks = 0, errors = 0;
  int mdl_owner, mdl_last, mdl_wait;
  bit mdl_terr;

  assign m_adr_i = {adr[3], adr[2], adr[1], adr[0]};
  assign m_dat_i = {wdat[3], wdat[2], wdat[1], wdat[0]};
  assign m_sel_i = {sel[3], sel[2], sel[1], sel[0]};

  wbc_rr_arbiter #(.DW(DW), .AW(AW), .SW(SW), .TIMEOUT(TO), .TW(TW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // reference: who owns the bus, who won last, how many strobes have gone unanswered
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mdl_owner = -1; mdl_last = 3; mdl_wait = 0; mdl_terr = 0;
    end else if (mdl_owner < 0) begin
      for (int k = 1; k <= 4; k++)
        if (mdl_owner < 0 && m_cyc_i[(mdl_last + k) % 4]) mdl_owner = (mdl_last + k) % 4;
      if (mdl_owner >= 0) mdl_last = mdl_owner;
    end else if (mdl_terr) begin
      mdl_terr = 0;
      if (!m_cyc_i[mdl_owner]) mdl_owner = -1;
    end else if (!m_cyc_i[mdl_owner]) begin
      mdl_owner = -1; mdl_wait = 0;
    end else if (m_stb_i[mdl_owner] && !(s_ack_i || s_err_i || s_rty_i)) begin
      mdl_wait++;
      if (mdl_wait == TO) begin mdl_terr = 1; mdl_wait = 0; end
    end else mdl_wait = 0;
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = '0;
    for (int m = 0; m < 4; m++) begin adr[m] = '0; wdat[m] = '0; sel[m] = '0; end
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_n_i = 0;
    clear_inputs();
    @(negedge clk_i);
    rst_n_i = 1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_n_i = 0;
    m_cyc_i = 4'hF; m_stb_i = 4'hF; m_we_i = 4'hF; s_ack_i = 1; s_err_i = 1; s_rty_i = 1;
    for (int m = 0; m < 4; m++) begin adr[m] = AW'($urandom); wdat[m] = $urandom; sel[m] = 4'hF; end
    #1;
    checks++;
    if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m_ack_o, m_err_o, m_rty_o, grant_o, timeout_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cyc=%b stb=%b we=%b adr=%h grant=%b ack=%b err=%b to=%b, want all 0",
               s_cyc_o, s_stb_o, s_we_o, s_adr_o, grant_o, m_ack_o, m_err_o, timeout_o);
    end
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    @(negedge clk_i);
    rst_n_i = 1;
    tick();
    checks++;
    if (grant_o !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", grant_o); end
  endtask

  task automatic test_two_masters();
    reset_dut();
    adr[PCIC] = 20'h11234; wdat[PCIC] = 32'h12345678;
    adr[TURFC] = 20'h05678; wdat[TURFC] = 32'h9ABCDEF0;
    m_cyc_i = 4'b0011; m_stb_i = 4'b0011; #1;
    checks++;
    if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL two_latency: s_cyc got %b want 0", s_cyc_o); end
    tick();
    s_ack_i = 1; #1;
    checks++;
    if ({s_adr_o, s_dat_o, m_ack_o} !== {20'h11234, 32'h12345678, 4'b0001}) begin
      errors++; $display("FAIL two_pcic: adr=%h dat=%h ack=%b want 11234 12345678 0001", s_adr_o, s_dat_o, m_ack_o);
    end
    tick();
    m_cyc_i[PCIC] = 0; m_stb_i[PCIC] = 0; s_ack_i = 0; #1;
    checks++;
    if ({s_cyc_o, grant_o} !== {1'b0, 4'b0001}) begin
      errors++; $display("FAIL two_drop: cyc=%b grant=%b want 0 0001", s_cyc_o, grant_o);
    end
    tick();
    checks++;
    if ({s_cyc_o, grant_o} !== {1'b0, 4'b0000}) begin
      errors++; $display("FAIL two_idle: cyc=%b grant=%b want 0 0000", s_cyc_o, grant_o);
    end
    tick();
    s_ack_i = 1; #1;
    checks++;
    if ({s_cyc_o, s_adr_o, s_dat_o, m_ack_o, grant_o} !== {1'b1, 20'h05678, 32'h9ABCDEF0, 4'b0010, 4'b0010}) begin
      errors++; $display("FAIL two_turfc: cyc=%b adr=%h dat=%h ack=%b grant=%b want 1 05678 9abcdef0 0010 0010",
                         s_cyc_o, s_adr_o, s_dat_o, m_ack_o, grant_o);
    end
    s_ack_i = 0;
  endtask

  task automatic test_rotation();
    int g;
    reset_dut();
    m_cyc_i = 4'hF; m_stb_i = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 6 && grant_o == 4'b0; k++) tick();
      g = i % 4;
      checks++;
      if (grant_o !== 4'(1 << g)) begin errors++; $display("FAIL rotation_%0d: grant got %b want %b", i, grant_o, 4'(1 << g)); end
      s_ack_i = 1; #1;
      checks++;
      if (m_ack_o !== 4'(1 << g)) begin errors++; $display("FAIL rotation_ack_%0d: got %b want %b", i, m_ack_o, 4'(1 << g)); end
      tick();
      m_cyc_i[g] = 0; m_stb_i[g] = 0; s_ack_i = 0;
      tick();
      m_cyc_i[g] = 1; m_stb_i[g] = 1;
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    m_cyc_i[WBVIO] = 1; m_stb_i[WBVIO] = 1;
    tick();
    for (int c = 1; c <= 18; c++) begin
      #1;
      checks++;
      if ({s_cyc_o, timeout_o, m_err_o} !== {c != 17, c == 17, (c == 17) ? 4'b1000 : 4'b0000}) begin
        errors++; $display("FAIL timeout_c%0d: cyc=%b to=%b err=%b want %b %b %b", c, s_cyc_o, timeout_o, m_err_o,
                           c != 17, c == 17, (c == 17) ? 4'b1000 : 4'b0000);
      end
      tick();
    end
  endtask

  task automatic test_ack_on_expiry();
    reset_dut();
    m_cyc_i[TURFC] = 1; m_stb_i[TURFC] = 1;
    tick();
    for (int c = 1; c < 16; c++) tick();
    s_ack_i = 1; #1;
    checks++;
    if ({m_ack_o, m_err_o, timeout_o} !== {4'b0010, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL expiry_ack: ack=%b err=%b to=%b want 0010 0000 0", m_ack_o, m_err_o, timeout_o);
    end
    tick();
    s_ack_i = 0; #1;
    checks++;
    if ({s_cyc_o, m_err_o, timeout_o} !== {1'b1, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL expiry_after: cyc=%b err=%b to=%b want 1 0000 0", s_cyc_o, m_err_o, timeout_o);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    m_cyc_i[HKMC] = 1; m_stb_i[HKMC] = 1;
    tick();
    s_ack_i = 1; #1;
    checks++;
    if ({grant_o, m_ack_o, s_cyc_o} !== {4'b0100, 4'b0100, 1'b1}) begin
      errors++; $display("FAIL areset_pre: grant=%b ack=%b cyc=%b want 0100 0100 1", grant_o, m_ack_o, s_cyc_o);
    end
    rst_n_i = 0; #1;
    checks++;
    if ({grant_o, m_ack_o, s_cyc_o} !== {4'b0000, 4'b0000, 1'b0}) begin
      errors++; $display("FAIL areset_async: grant=%b ack=%b cyc=%b want 0000 0000 0", grant_o, m_ack_o, s_cyc_o);
    end
    m_cyc_i = 4'hF; m_stb_i = 4'hF; s_ack_i = 0; #1;
    rst_n_i = 1;
    tick();
    checks++;
    if (grant_o !== 4'b0001) begin errors++; $display("FAIL areset_first: grant got %b want 0001", grant_o); end
  endtask

  task automatic test_late_ack();
    reset_dut();
    m_cyc_i = 4'b0011; m_stb_i = 4'b0011;
    tick();
    tick();
    m_cyc_i[PCIC] = 0; m_stb_i[PCIC] = 0; s_ack_i = 1; #1;
    checks++;
    if ({s_cyc_o, m_ack_o} !== {1'b0, 4'b0000}) begin
      errors++; $display("FAIL late_ack_drop: cyc=%b ack=%b want 0 0000", s_cyc_o, m_ack_o);
    end
    tick();
    s_ack_i = 0; #1;
    checks++;
    if ({s_cyc_o, grant_o} !== {1'b0, 4'b0000}) begin
      errors++; $display("FAIL late_ack_idle: cyc=%b grant=%b want 0 0000", s_cyc_o, grant_o);
    end
    tick();
    checks++;
    if ({s_cyc_o, grant_o} !== {1'b1, 4'b0010}) begin
      errors++; $display("FAIL late_ack_next: cyc=%b grant=%b want 1 0010", s_cyc_o, grant_o);
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_v, got_v;
    logic [3:0] gv;
    bit busy, route, hung;
    int gi;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      hung = (i / 300) % 3 == 2;
      for (int m = 0; m < 4; m++) begin
        if (!m_cyc_i[m]) begin
          if ($urandom_range(3) == 0) begin
            m_cyc_i[m] = 1; m_stb_i[m] = 1; m_we_i[m] = 1'($urandom);
            adr[m] = AW'($urandom); wdat[m] = $urandom; sel[m] = SW'($urandom);
          end
        end else if (m == mdl_owner) begin
          if ($urandom_range(hung ? 40 : 5) == 0) begin m_cyc_i[m] = 0; m_stb_i[m] = 0; end
          else m_stb_i[m] = hung || $urandom_range(3) != 0;
        end
      end
      s_ack_i = !hung && $urandom_range(2) == 0;
      s_err_i = !hung && $urandom_range(15) == 0;
      s_rty_i = !hung && $urandom_range(15) == 0;
      s_dat_i = $urandom;
      #1;
      gi = mdl_owner < 0 ? 0 : mdl_owner;
      busy = mdl_owner >= 0 && !mdl_terr;
      route = busy && m_cyc_i[gi];
      gv = mdl_owner >= 0 ? 4'(1 << gi) : 4'b0;
      exp_v = {route, route && m_stb_i[gi], busy && m_we_i[gi],
               busy ? adr[gi] : {AW{1'b0}}, busy ? wdat[gi] : {DW{1'b0}}, busy ? sel[gi] : {SW{1'b0}},
               (route && s_ack_i) ? gv : 4'b0, (mdl_terr || (route && s_err_i)) ? gv : 4'b0,
               (route && s_rty_i) ? gv : 4'b0, gv, mdl_terr, s_dat_i};
      got_v = {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, m_ack_o, m_err_o, m_rty_o,
               grant_o, timeout_o, m_dat_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL random_cycle_%0d: got %h want %h", i, got_v, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_i = 0;
    clear_inputs();
    test_reset();
    test_two_masters();
    test_rotation();
    test_timeout();
    test_ack_on_expiry();
    test_async_reset();
    test_late_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
